// File: rtl/activation_sequencer_if.sv
// Command and beat handshake between a sequence controller and the activation sequencer.
interface activation_sequencer_if #(
    parameter int unsigned COUNTER_WIDTH = 5
);
    logic                     start;
    logic [COUNTER_WIDTH-1:0] base_value;
    logic [COUNTER_WIDTH-1:0] length;
    logic                     abort;
    logic                     out_ready;
    logic [COUNTER_WIDTH-1:0] iterator;
    logic                     out_valid;
    logic                     last;
    logic                     busy;
    logic                     done;

    modport master (
        output start, base_value, length, abort, out_ready,
        input  iterator, out_valid, last, busy, done
    );

    modport slave (
        input  start, base_value, length, abort, out_ready,
        output iterator, out_valid, last, busy, done
    );
endinterface

// File: rtl/activation_sequencer.sv
// Issues a run of consecutive element indices (base_value .. base_value+length-1,
// wrapping modulo 2^W) to the activation datapath over a valid/ready handshake.
module activation_sequencer #(
    parameter int unsigned COUNTER_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clock_enable,
    activation_sequencer_if.slave bus
);
    localparam int unsigned W = COUNTER_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   iter_q, iter_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // State, counters and registered outputs; everything holds while clock_enable is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clock_enable) begin
            state_q <= state_d;
            iter_q  <= iter_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter update and next-output decode; abort beats a simultaneous transfer.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        iter_d  = bus.base_value;
                        rem_d   = bus.length;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    if (rem_q == W'(1)) begin
                        state_d = DONE;
                    end else begin
                        iter_d = iter_q + W'(1);
                        rem_d  = rem_q - W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == RUN);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
        last_d  = (state_d == RUN) && (rem_d == W'(1));
    end

    assign bus.iterator  = iter_q;
    assign bus.out_valid = valid_q;
    assign bus.last      = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_activation_sequencer.sv
// Directed bench: expected beats and done pulses are queued by the stimulus,
// and a negedge monitor pops and compares them as the DUT presents them.
module tb_activation_sequencer;
    typedef struct packed {
        logic [4:0] iter;
        logic       last;
    } beat_t;

    logic clock;
    logic reset;
    logic clock_enable;

    activation_sequencer_if #(.COUNTER_WIDTH(5)) bus ();

    activation_sequencer #(.COUNTER_WIDTH(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .clock_enable (clock_enable),
        .bus          (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    xfers  = 0;
    beat_t beat_q[$];
    bit    done_q[$];
    beat_t mon_exp;
    bit    mon_done;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Monitor: each transfer and each done pulse must match the head of its queue.
    always @(negedge clock) begin
        if (reset && clock_enable && bus.out_valid && bus.out_ready && !bus.abort) begin
            checks++;
            xfers++;
            if (beat_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: actual iterator=%0d last=%0d, required no beat",
                         bus.iterator, bus.last);
            end else begin
                mon_exp = beat_q.pop_front();
                if (bus.iterator !== mon_exp.iter || bus.last !== mon_exp.last) begin
                    errors++;
                    $display("FAIL beat: actual iterator=%0d last=%0d, required iterator=%0d last=%0d",
                             bus.iterator, bus.last, mon_exp.iter, mon_exp.last);
                end
            end
        end
        if (bus.done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: actual done=1, required done=0");
            end else begin
                mon_done = done_q.pop_front();
            end
        end
        checks++;
        if (bus.busy !== bus.out_valid) begin
            errors++;
            $display("FAIL busy_vs_valid: actual busy=%0d, required %0d", bus.busy, bus.out_valid);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_beat(input int it, input bit l);
        beat_t b;
        b.iter = 5'(it);
        b.last = l;
        beat_q.push_back(b);
    endtask

    task automatic do_start(input int b, input int l);
        bus.base_value = 5'(b);
        bus.length     = 5'(l);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.base_value = 5'd9;
        bus.length     = 5'd2;
    endtask

    // One RUN cycle with the given ready, checking the presented beat.
    task automatic cyc(input logic rdy, input int exp_iter, input string tag);
        bus.out_ready = rdy;
        @(negedge clock);
        check({tag, "_iter"}, 32'(bus.iterator), 32'(exp_iter));
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        @(posedge clock);
        #1;
    endtask

    // Counts negedges until done is seen; 0 means it never came within the budget.
    task automatic wait_done(input int exp_cycles, input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
        check(tag, 32'(n), 32'(exp_cycles));
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        clock_enable   = 1'b1;
        bus.start      = 1'b0;
        bus.base_value = '0;
        bus.length     = '0;
        bus.abort      = 1'b0;
        bus.out_ready  = 1'b0;
        #2 reset = 1'b0;
        repeat (2) tick();
        check("rst_iter", 32'(bus.iterator), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_last", 32'(bus.last), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        tick();

        // Wrap-around run with ready always high.
        bus.out_ready = 1'b1;
        push_beat(30, 0); push_beat(31, 0); push_beat(0, 0); push_beat(1, 1);
        done_q.push_back(1'b1);
        do_start(30, 4);
        wait_done(5, "wrap_done_latency");

        // Backpressure; a start asserted mid-run must be ignored.
        xfers = 0;
        push_beat(3, 0); push_beat(4, 0); push_beat(5, 1);
        done_q.push_back(1'b1);
        do_start(3, 3);
        cyc(1'b1, 3, "bp1");
        bus.start = 1'b1; bus.base_value = 5'd0; bus.length = 5'd7;
        cyc(1'b0, 4, "bp2");
        cyc(1'b0, 4, "bp3");
        bus.start = 1'b0;
        cyc(1'b1, 4, "bp4");
        cyc(1'b1, 5, "bp5");
        @(negedge clock);
        check("bp_done", 32'(bus.done), 32'd1);
        check("bp_xfers", 32'(xfers), 32'd3);
        tick();

        // Zero-length start goes straight to a done pulse.
        done_q.push_back(1'b1);
        do_start(12, 0);
        @(negedge clock);
        check("zero_valid", 32'(bus.out_valid), 32'd0);
        check("zero_busy", 32'(bus.busy), 32'd0);
        check("zero_done", 32'(bus.done), 32'd1);
        tick();
        @(negedge clock);
        check("zero_done_after", 32'(bus.done), 32'd0);
        check("zero_busy_after", 32'(bus.busy), 32'd0);
        tick();

        // Abort on the third beat, together with ready.
        xfers = 0;
        push_beat(0, 0); push_beat(1, 0);
        do_start(0, 8);
        cyc(1'b1, 0, "ab1");
        cyc(1'b1, 1, "ab2");
        bus.abort = 1'b1;
        cyc(1'b1, 2, "ab3");
        bus.abort = 1'b0;
        @(negedge clock);
        check("ab_valid", 32'(bus.out_valid), 32'd0);
        check("ab_busy", 32'(bus.busy), 32'd0);
        repeat (3) tick();
        check("ab_xfers", 32'(xfers), 32'd2);

        // Clock-enable stall mid-run.
        push_beat(10, 0); push_beat(11, 0); push_beat(12, 0); push_beat(13, 0); push_beat(14, 1);
        done_q.push_back(1'b1);
        do_start(10, 5);
        cyc(1'b1, 10, "st1");
        clock_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_iter", 32'(bus.iterator), 32'd11);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_last", 32'(bus.last), 32'd0);
            tick();
        end
        clock_enable = 1'b1;
        wait_done(5, "stall_done_latency");

        // Asynchronous reset mid-run, then a single-beat sequence.
        push_beat(20, 0); push_beat(21, 0);
        do_start(20, 6);
        cyc(1'b1, 20, "rr1");
        cyc(1'b1, 21, "rr2");
        #2 reset = 1'b0;
        #1;
        check("arst_iter", 32'(bus.iterator), 32'd0);
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_last", 32'(bus.last), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        push_beat(7, 1);
        done_q.push_back(1'b1);
        do_start(7, 1);
        wait_done(2, "single_done_latency");
        repeat (2) tick();

        check("beats_left", 32'(beat_q.size()), 32'd0);
        check("dones_left", 32'(done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/activation_sequencer.md
ACTIVATION_SEQUENCER -- requirements
Module: activation_sequencer

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 5, giving the width W of iterator, base_value and length.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clock_enable  input  1  global stall; when low, all state holds.
REQ-005 SHALL have port start  input  1  request to begin a sequence; sampled in IDLE only.
REQ-006 SHALL have port base_value  input  W  first iterator value, captured on an accepted start.
REQ-007 SHALL have port length  input  W  number of beats to issue, captured on an accepted start; 0 means no beats.
REQ-008 SHALL have port abort  input  1  terminates an active sequence.
REQ-009 SHALL have port out_ready  input  1  downstream activation datapath accepts the current iterator.
REQ-010 SHALL have port iterator  output  W  current element index presented downstream.
REQ-011 SHALL have port out_valid  output  1  iterator is valid for transfer.
REQ-012 SHALL have port last  output  1  current beat is the final beat of the sequence.
REQ-013 SHALL have port busy  output  1  a sequence is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse marking sequence completion.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE; all transitions occur only on clock edges with clock_enable=1.
REQ-016 SHALL, in IDLE on start=1 with length!=0, load iterator<=base_value and remaining<=length, then move to RUN.
REQ-017 SHALL, in IDLE on start=1 with length==0, move directly to DONE without asserting out_valid.
REQ-018 SHALL drive out_valid=1 and busy=1 in RUN and only in RUN, so the first beat appears one cycle after an accepted start.
REQ-019 SHALL treat a beat as transferred only when out_valid, out_ready and clock_enable are all 1 in the same cycle.
REQ-020 SHALL, on a transfer with remaining>1, increment iterator modulo 2^W (all-ones wraps to 0) and decrement remaining.
REQ-021 SHALL, on a transfer with remaining==1, move to DONE, leaving iterator unchanged.
REQ-022 SHALL drive last=1 exactly when out_valid=1 and remaining==1.
REQ-023 SHALL, while out_ready=0 in RUN, hold iterator, last and out_valid stable; out_valid never drops before its transfer unless abort is asserted.
REQ-024 SHALL, while clock_enable=0, freeze state, iterator and remaining; outputs SHALL hold their values.
REQ-025 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE; busy=0 in DONE.
REQ-026 SHALL ignore start while in RUN or DONE; no re-capture of base_value or length occurs.
REQ-027 SHALL, on abort=1 in RUN, return to IDLE on the next enabled edge with no done pulse; abort takes priority over a simultaneous transfer, and that beat is not counted.
REQ-028 SHALL ignore abort in IDLE and DONE.
REQ-029 SHALL, with out_ready held high, complete N beats so that done asserts N+1 cycles after the cycle in which start is accepted.

Reset
REQ-030 SHALL, on reset=0, immediately enter IDLE and clear iterator, remaining, out_valid, last, busy and done to 0, regardless of clock or clock_enable.
REQ-031 SHALL, after a reset asserted mid-sequence and then released, produce no done pulse and SHALL accept a new start normally.

Verification
REQ-032 Bench SHALL cover: base_value=5'b11110, length=4, out_ready=1 -> iterator 30,31,0,1 on consecutive cycles; last on 1; done one cycle later.
REQ-033 Bench SHALL cover: base_value=3, length=3, out_ready toggling 1,0,0,1,1 -> iterator 3,4,4,4,5; out_valid continuously high; exactly 3 transfers.
REQ-034 Bench SHALL cover: length=0, start=1 -> out_valid never asserts; done pulses one cycle after start; busy stays 0.
REQ-035 Bench SHALL cover: base_value=0, length=8, abort=1 on the third beat together with out_ready=1 -> IDLE next cycle; no done; only 2 transfers counted.
REQ-036 Bench SHALL cover: clock_enable=0 for 3 cycles mid-RUN -> iterator and outputs frozen; sequence resumes correctly afterwards.
REQ-037 Bench SHALL cover: reset=0 asserted asynchronously between clock edges while in RUN -> all outputs 0 immediately; a new start with base_value=7, length=1 afterwards yields a single beat with iterator=7, last=1, then done.
